// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state type and default sizing for the bus arbiter
package bus_arb_pkg;
  typedef enum logic {IDLE, OWNED} state_t;
  localparam int NUM_REQ_DEF  = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_HOLD_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search from ptr over req with an exclude mask
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0]  m;
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  assign m     = req & ~excl;
  // doubling the vector makes the rotate-by-ptr a plain shift
  assign rot   = N'({m, m} >> ptr);
  assign found = |m;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with registered one-hot grant and hold limit
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IW-1:0]             gnt_idx,
  output logic                      bus_valid,
  output logic [DATA_W-1:0]         bus_data
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, excl;
  logic [IW-1:0]      idx_q, idx_d, ptr_q, ptr_d, win;
  logic [HW-1:0]      hold_q, hold_d;
  logic               found, own_req, at_max;
  logic [DATA_W-1:0]  slice [NUM_REQ];

  assign own_req = (state_q == OWNED) && req[idx_q];
  assign at_max  = hold_q == HW'(MAX_HOLD - 1);
  // a still-requesting owner is only searched past when its hold has expired
  assign excl    = own_req ? gnt_q : '0;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .excl  (excl),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    hold_d  = own_req ? (at_max ? '0 : hold_q + 1'b1) : '0;
    if ((!own_req || at_max) && found) begin
      state_d = OWNED;
      idx_d   = win;
      gnt_d   = NUM_REQ'(1) << win;
      ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      hold_d  = '0;
    end else if (!own_req) begin
      state_d = IDLE;
      idx_d   = '0;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = data_in[g*DATA_W +: DATA_W];
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign bus_valid = state_q == OWNED;
  assign bus_data  = bus_valid ? slice[idx_q] : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a queue-free integer model
module tb_bus_arbiter;
  localparam int N = 8, DW = 32, MH = 4, BOUND = (N - 1) * MH + 1;
  logic clk = 1'b0, clr;
  logic [N-1:0] req, gnt;
  logic [N*DW-1:0] data_in;
  logic [2:0] gnt_idx;
  logic bus_valid;
  logic [DW-1:0] bus_data;
  int checks = 0, errors = 0;
  int m_owner, m_ptr, m_hold;
  int wt [N];

  bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .clr(clr), .req(req), .data_in(data_in),
    .gnt(gnt), .gnt_idx(gnt_idx), .bus_valid(bus_valid), .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p, input int ex);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j] && j != ex) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    foreach (wt[i]) wt[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    bit keep;
    keep = (m_owner >= 0) ? r[m_owner] : 1'b0;
    if (keep && m_hold < MH - 1) m_hold++;
    else begin
      w = pick(r, m_ptr, keep ? m_owner : -1);
      m_hold = 0;
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
      end else if (!keep) m_owner = -1;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    logic [DW-1:0] ed;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    ed = (m_owner >= 0) ? data_in[m_owner*DW +: DW] : '0;
    check("m_gnt", gnt, eg);
    check("m_idx", gnt_idx, (m_owner >= 0) ? m_owner : 0);
    check("m_valid", bus_valid, m_owner >= 0);
    check("m_data", bus_data, ed);
  endtask

  task automatic monitor();
    int mx = 0;
    check("onehot", $onehot0(gnt), 1);
    check("idx_match", (gnt == 0) ? (gnt_idx == 0) : gnt[gnt_idx], 1);
    for (int i = 0; i < N; i++) begin
      wt[i] = (req[i] && !gnt[i]) ? wt[i] + 1 : 0;
      if (wt[i] > mx) mx = wt[i];
    end
    check("starve", mx <= BOUND, 1);
  endtask

  task automatic tick(input logic [N-1:0] r);
    req = r;
    model_step(r);
    @(negedge clk);
    compare_model();
    monitor();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    req = '0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_idx", gnt_idx, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_data", bus_data, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    clr = 1'b1;
    req = '0;
    data_in = '0;
    model_reset();
    do_reset();
    data_in[31:0] = 32'hDEADBEEF;
    tick(8'h01);
    check("first_gnt", gnt, 8'h01);
    check("first_idx", gnt_idx, 0);
    check("first_valid", bus_valid, 1);
    check("first_data", bus_data, 32'hDEADBEEF);

    do_reset();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 32'h1000_0000 + i;
    for (int c = 0; c < 40; c++) begin
      tick(8'hFF);
      check("rr_owner", gnt_idx, (c / 4) % 8);
      check("rr_ptr", dut.ptr_q, ((c / 4) % 8 + 1) % 8);
    end

    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(8'h80);
      check("solo_gnt", gnt, 8'h80);
      check("solo_hold", dut.hold_q, c % 4);
    end

    do_reset();
    tick(8'h04);
    tick(8'h24);
    check("drop_keep", gnt, 8'h04);
    tick(8'h20);
    check("drop_gnt", gnt, 8'h20);
    check("drop_valid", bus_valid, 1);
    tick(8'h00);
    check("idle_gnt", gnt, 0);
    check("idle_valid", bus_valid, 0);
    check("idle_data", bus_data, 0);

    do_reset();
    data_in[4*DW +: DW] = 32'hA5A5_0004;
    tick(8'h10);
    check("pre_clr_gnt", gnt, 8'h10);
    #2 clr = 1'b1;
    #1;
    check("async_gnt", gnt, 0);
    check("async_valid", bus_valid, 0);
    check("async_data", bus_data, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    tick(8'h30);
    check("post_clr_gnt", gnt, 8'h10);

    do_reset();
    r = N'($urandom);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) r[i] = ~r[i];
        data_in[i*DW +: DW] = $urandom;
      end
      tick(r);
      data_in[$urandom_range(N-1)*DW +: DW] = $urandom;
      #1 compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
